// File: rtl/pwm_duty_slew_if.sv
// Duty-request / slewed-duty bundle between the SPI register file side and the
// slew limiter feeding the PWM peripheral.
interface pwm_duty_slew_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic [WIDTH-1:0]  target_duty;
    logic [STEP_W-1:0] step;
    logic              hold;
    logic [WIDTH-1:0]  duty_out;
    logic [1:0]        ramp_state;
    logic              busy;
    logic              done;

    modport master (
        output target_duty, step, hold,
        input  duty_out, ramp_state, busy, done
    );

    modport slave (
        input  target_duty, step, hold,
        output duty_out, ramp_state, busy, done
    );
endinterface

// File: rtl/pwm_duty_slew.sv
// Soft-start / slew limiter: walks duty_out toward target_duty by at most `step`
// counts every TICK_DIV clocks so the PWM outputs never jump abruptly.
module pwm_duty_slew #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int TICK_DIV = 3333
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_duty_slew_if.slave bus
);
    localparam int              CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_HELD = 2'b11
    } ramp_t;

    logic [WIDTH-1:0] duty_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;

    ramp_t            state_s;
    logic             tick_s;
    logic             bypass_s;
    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] up_s;
    logic [WIDTH-1:0] down_s;
    logic [WIDTH-1:0] next_s;

    assign tick_s     = (cnt_r == TICK_LAST);
    assign bypass_s   = (bus.step == {STEP_W{1'b0}});
    assign step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};

    // Ramp direction; hold outranks everything, including bypass.
    always_comb begin
        if (bus.hold) begin
            state_s = ST_HELD;
        end else if (duty_r == bus.target_duty) begin
            state_s = ST_IDLE;
        end else if (duty_r < bus.target_duty) begin
            state_s = ST_UP;
        end else begin
            state_s = ST_DOWN;
        end
    end

    // Candidate next duty, clamped at target; the extra bit catches wrap/underflow.
    always_comb begin
        sum_s  = {1'b0, duty_r} + step_ext_s;
        diff_s = {1'b0, duty_r} - step_ext_s;
        if (sum_s > {1'b0, bus.target_duty}) begin
            up_s = bus.target_duty;
        end else begin
            up_s = sum_s[WIDTH-1:0];
        end
        if (diff_s[WIDTH] || (diff_s[WIDTH-1:0] < bus.target_duty)) begin
            down_s = bus.target_duty;
        end else begin
            down_s = diff_s[WIDTH-1:0];
        end
        if (state_s == ST_UP) begin
            next_s = up_s;
        end else begin
            next_s = down_s;
        end
    end

    // Prescaler, duty register and the on-target pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_s)
                ST_HELD: begin
                    duty_r <= duty_r;
                    cnt_r  <= cnt_r;
                end
                ST_IDLE: begin
                    duty_r <= duty_r;
                    cnt_r  <= {CNT_W{1'b0}};
                end
                ST_UP, ST_DOWN: begin
                    if (bypass_s) begin
                        duty_r <= bus.target_duty;
                        cnt_r  <= {CNT_W{1'b0}};
                    end else if (tick_s) begin
                        duty_r <= next_s;
                        cnt_r  <= {CNT_W{1'b0}};
                        done_r <= (next_s == bus.target_duty);
                    end else begin
                        duty_r <= duty_r;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    duty_r <= duty_r;
                    cnt_r  <= cnt_r;
                end
            endcase
        end
    end

    assign bus.duty_out   = duty_r;
    assign bus.ramp_state = state_s;
    assign bus.busy       = (duty_r != bus.target_duty);
    assign bus.done       = done_r;
endmodule
